axi_dut_modport: RTL and testbench
==================================

Name: axi_dut_modport

Overview:
- AXI3-style slave memory that implements the dut side of the codebase AXI interface: AW, W, B, AR and R channels.
- 4-bit IDs, 32-bit address, 32-bit data, byte write strobes.
- Serves as the standard target behind the AXI BFM in block-level benches.
- One write burst and one read burst outstanding at a time; the read and write paths are independent.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in internal storage; byte address range is 0 to 4*MEM_WORDS-1.
- ID_W, 4: width of awid/wid/bid/arid/rid.

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  synchronous active-low reset
awid  in  ID_W  write ID
awaddr  in  32  write start byte address
awlen  in  4  beats-1
awsize  in  3  log2 bytes/beat
awburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
awlock  in  2  ignored (normal access)
awcache  in  4  ignored
awprot  in  3  ignored
awvalid  in  1  / awready out 1: AW handshake
wid  in  ID_W  write data ID
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  final write beat
wvalid  in  1  / wready out 1: W handshake
bid  out  ID_W  = captured awid
bresp  out  2  0 OKAY, 2 SLVERR, 3 DECERR
bvalid  out  1  / bready in 1: B handshake
arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  in  (same widths as AW)
arready  out  1
rid  out  ID_W  = captured arid
rdata  out  32  read data
rresp  out  2  as bresp
rlast  out  1  final read beat
rvalid  out  1  / rready in 1: R handshake

Behaviour:
- Reset: aresetn sampled on the aclk rising edge. While low, every output is 0: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata. Memory contents are not reset.
- First cycle after release: awready=1 and arready=1.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid&awready, capture id/addr/len/size/burst, clear error flags, go to W_DATA. awready=0 from the next cycle.
  - W_DATA: wready=1. Each wvalid&wready beat writes the wstrb-enabled bytes of wdata to word addr[31:2], using the byte lanes of the current beat address. A beat is written only when it is in range and no SLVERR is flagged. The address is then advanced.
  - Burst end is counted, not driven by wlast: after awlen+1 beats, go to W_RESP.
  - Protocol error: wlast=1 on any earlier beat, or wlast=0 on the final beat, flags SLVERR.
  - W_RESP: bvalid=1 with bid and bresp. Hold until bready, then return to W_IDLE with awready=1 in the next cycle.
  - Minimum write latency: AW handshake cycle N; wready high N+1; single-beat W at N+1; bvalid N+2.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On handshake, capture the AR fields and go to R_DATA.
  - R_DATA: rvalid=1 from the cycle after the AR handshake, rdata = mem[addr[31:2]] (0 if out of range), rresp per beat.
  - Each rvalid&rready advances the address and the count. rlast=1 on beat arlen+1.
  - rvalid, rdata, rresp and rlast hold stable while rready=0.
  - After the last beat, return to R_IDLE.
- Address advance (size S, bytes B=2^S):
  - FIXED: unchanged.
  - INCR: addr+B.
  - WRAP: addr+B, wrapping within a window of (len+1)*B bytes, aligned to that window.
- Response priority, computed per burst at AW/AR acceptance:
  - SLVERR if S>2, burst==3, WRAP with len not in {1,3,7,15}, or WRAP with an unaligned start address.
  - Otherwise, DECERR for any beat whose word index >= MEM_WORDS.
  - Otherwise OKAY.
  - bresp reports the worst response across the burst (SLVERR > DECERR > OKAY).
  - Errored write beats do not modify memory.
- Exclusive access (awlock/arlock=1) is not supported: treated as normal, never EXOKAY.
- Read and write to the same word in the same cycle: the read returns the old data.

Optional Feature:
- AXI_WID_CHECK_EN defined: every accepted W beat must have wid equal to the captured awid. On mismatch the beat is not written and bresp=SLVERR.
- Undefined: wid is ignored.

Test Plan:
- Reset low 3 cycles then high: all outputs 0 during reset; awready=arready=1 on the first post-reset cycle.
- Write INCR: awaddr=0x10, len=3, size=2, data 0xA0..0xA3, wstrb=0xF, wlast on beat 4 -> bid=awid, bresp=0. Read back same burst -> rdata 0xA0..0xA3, rlast only on beat 4.
- Narrow/strobe write: awaddr=0x21, size=0, wdata=0x0000BB00, wstrb=0x2 onto a word holding 0x11223344 -> read 0x1122BB44.
- WRAP read: araddr=0x38, len=3, size=2 -> beat addresses 0x38, 0x3C, 0x30, 0x34.
- Error cases, MEM_WORDS=1024:
  - awaddr=0x1000 -> bresp=3, memory unchanged.
  - awsize=3 -> bresp=2.
  - Early wlast on beat 2 of a len=3 burst -> bresp=2.
- Backpressure: hold rready=0 for 5 cycles mid-burst -> rdata, rlast and rvalid stable. Hold bready=0 -> bvalid held and awready stays 0 until B completes.

Source files
------------

// File: rtl/axi_dut_modport_if.sv
// AXI3-style bus bundle (AW, W, B, AR, R) used between the BFM and the
// axi_dut_modport target. The master modport drives requests; the slave
// modport drives ready/response signals.
interface axi_dut_modport_if #(
  parameter int ID_W = 4
) ();
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_dut_modport.sv
// AXI3-style slave memory: one write and one read burst outstanding, with
// independent read/write FSMs, FIXED/INCR/WRAP bursts and byte strobes.
// Optional macro AXI_WID_CHECK_EN: W beats whose wid differs from the captured
// awid are dropped and the burst answers SLVERR.
module axi_dut_modport #(
  parameter int MEM_WORDS = 1024,
  parameter int ID_W      = 4
) (
  input logic                aclk,
  input logic                aresetn,
  axi_dut_modport_if.slave   s_axi
);
  localparam int AIW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [31:0] r_mem [MEM_WORDS];

  wstate_t         r_wstate;
  logic            r_awready, r_wready, r_bvalid;
  logic [1:0]      r_bresp;
  logic [ID_W-1:0] r_awid;
  logic [31:0]     r_awaddr;
  logic [3:0]      r_awlen, r_wcnt;
  logic [2:0]      r_awsize;
  logic [1:0]      r_awburst;
  logic            r_wslv, r_wdec;

  rstate_t         r_rstate;
  logic            r_arready, r_rvalid, r_rlast;
  logic [1:0]      r_rresp;
  logic [31:0]     r_rdata;
  logic [ID_W-1:0] r_arid;
  logic [31:0]     r_araddr;
  logic [3:0]      r_arlen, r_rcnt;
  logic [2:0]      r_arsize;
  logic [1:0]      r_arburst;
  logic            r_rslv;

  function automatic logic [31:0] f_next(input logic [31:0] a, input logic [2:0] s,
                                         input logic [3:0] len, input logic [1:0] burst);
    logic [31:0] inc, wmask, res;
    inc   = a + (32'd1 << s);
    wmask = (({28'd0, len} + 32'd1) << s) - 32'd1;
    case (burst)
      2'd0:    res = a;
      2'd2:    res = (a & ~wmask) | (inc & wmask);
      default: res = inc;
    endcase
    return res;
  endfunction

  function automatic logic f_slverr(input logic [31:0] a, input logic [2:0] s,
                                    input logic [3:0] len, input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (s > 3'd2) || (burst == 2'd3) ||
           ((burst == 2'd2) && (!wrap_len_ok || ((a & ((32'd1 << s) - 32'd1)) != '0)));
  endfunction

  function automatic logic f_oor(input logic [31:0] a);
    return {2'b00, a[31:2]} >= 32'(MEM_WORDS);
  endfunction

  // Lanes run from the address offset up to the end of the size-aligned container.
  function automatic logic [3:0] f_lanes(input logic [31:0] a, input logic [2:0] s);
    logic [2:0] lo, hi;
    logic [3:0] m;
    lo = {1'b0, a[1:0]};
    case (s)
      3'd0:    hi = {1'b0, a[1:0]};
      3'd1:    hi = {1'b0, a[1], 1'b1};
      default: hi = 3'd3;
    endcase
    m = '0;
    for (int unsigned i = 0; i < 4; i++) m[i] = (3'(i) >= lo) && (3'(i) <= hi);
    return m;
  endfunction

  logic            w_wlast_beat, w_wid_bad, w_whs, w_wbeat_slv, w_wbeat_dec, w_mem_we;
  logic [3:0]      w_wlanes;
  logic [AIW-1:0]  w_widx;
  logic            w_rd_slv, w_rd_dec;
  logic [31:0]     w_rd_addr, w_rd_data;
  logic [1:0]      w_rd_resp;
  logic            w_unused;

`ifdef AXI_WID_CHECK_EN
  assign w_wid_bad = (s_axi.wid != r_awid);
  assign w_unused  = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                       s_axi.arlock, s_axi.arcache, s_axi.arprot};
`else
  assign w_wid_bad = 1'b0;
  assign w_unused  = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                       s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.wid};
`endif

  // Per-beat write qualification; error flags are sticky for the rest of the burst
  always_comb begin
    w_wlast_beat = (r_wcnt == r_awlen);
    w_whs        = (r_wstate == W_DATA) && r_wready && s_axi.wvalid;
    w_wbeat_slv  = r_wslv || (s_axi.wlast != w_wlast_beat) || w_wid_bad;
    w_wbeat_dec  = f_oor(r_awaddr);
    w_mem_we     = w_whs && !w_wbeat_slv && !w_wbeat_dec;
    w_wlanes     = f_lanes(r_awaddr, r_awsize) & s_axi.wstrb;
    w_widx       = r_awaddr[AIW+1:2];
  end

  // Address of the read beat to be presented next: AR start in idle, else the advanced address
  always_comb begin
    w_rd_addr = (r_rstate == R_IDLE) ? s_axi.araddr
                                     : f_next(r_araddr, r_arsize, r_arlen, r_arburst);
    w_rd_slv  = (r_rstate == R_IDLE) ? f_slverr(s_axi.araddr, s_axi.arsize, s_axi.arlen, s_axi.arburst)
                                     : r_rslv;
    w_rd_dec  = f_oor(w_rd_addr);
    w_rd_resp = w_rd_slv ? 2'd2 : (w_rd_dec ? 2'd3 : 2'd0);
    w_rd_data = (w_rd_slv || w_rd_dec) ? '0 : r_mem[w_rd_addr[AIW+1:2]];
  end

  // Byte-lane memory write for accepted, error-free W beats
  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wlanes[i]) r_mem[w_widx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
    end
  end

  // Write FSM: AW capture, counted W beats, B response held until bready
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
      r_wslv    <= 1'b0;
      r_wdec    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (s_axi.awvalid && r_awready) begin
            r_awid    <= s_axi.awid;
            r_awaddr  <= s_axi.awaddr;
            r_awlen   <= s_axi.awlen;
            r_awsize  <= s_axi.awsize;
            r_awburst <= s_axi.awburst;
            r_wslv    <= f_slverr(s_axi.awaddr, s_axi.awsize, s_axi.awlen, s_axi.awburst);
            r_wdec    <= 1'b0;
            r_wcnt    <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_whs) begin
            r_awaddr <= f_next(r_awaddr, r_awsize, r_awlen, r_awburst);
            r_wcnt   <= r_wcnt + 4'd1;
            r_wslv   <= w_wbeat_slv;
            r_wdec   <= r_wdec || w_wbeat_dec;
            if (w_wlast_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_wbeat_slv ? 2'd2 : ((r_wdec || w_wbeat_dec) ? 2'd3 : 2'd0);
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: R beat data is registered and only reloaded on a handshake
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= '0;
      r_rdata   <= '0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
      r_rslv    <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s_axi.arvalid && r_arready) begin
            r_arid    <= s_axi.arid;
            r_araddr  <= s_axi.araddr;
            r_arlen   <= s_axi.arlen;
            r_arsize  <= s_axi.arsize;
            r_arburst <= s_axi.arburst;
            r_rslv    <= w_rd_slv;
            r_rcnt    <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (s_axi.arlen == 4'd0);
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_araddr <= w_rd_addr;
              r_rcnt   <= r_rcnt + 4'd1;
              r_rlast  <= ((r_rcnt + 4'd1) == r_arlen);
              r_rdata  <= w_rd_data;
              r_rresp  <= w_rd_resp;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.bid     = r_awid;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rid     = r_arid;
endmodule

// File: tb/tb_axi_dut_modport.sv
// Self-checking bench for axi_dut_modport: directed cases plus randomized
// bursts against a byte-level memory model with known-byte tracking.
module tb_axi_dut_modport;
  logic aclk;
  logic aresetn;
  int   n_tests;
  int   n_fail;

  axi_dut_modport_if #(.ID_W(4)) axi ();

  axi_dut_modport #(.MEM_WORDS(1024), .ID_W(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] mdl [1024];
  logic [3:0]  kn  [1024];
  logic [31:0] wd  [16];
  logic [3:0]  ws  [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    logic [31:0] b, win, base;
    b   = 32'd1 << size;
    win = 32'(len + 1) * b;
    if (burst == 0) return a;
    if (burst == 2) begin
      base = a - (a % win);
      return base + ((a - base + 32'(i) * b) % win);
    end
    return a + 32'(i) * b;
  endfunction

  function automatic bit burst_bad(input logic [31:0] a, input int len, input int size, input int burst);
    if (size > 2 || burst == 3) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == 2 && (a % (32'd1 << size)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int early, input int bhold);
    bit slv, dec, wl;
    logic [31:0] ba;
    logic [1:0] eresp;
    int n, lo;
    slv = burst_bad(addr, len, size, burst);
    dec = 1'b0;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(addr, len, size, burst, i);
      wl = (early >= 0) ? (i == early) : (i == len);
      if (wl != (i == len)) slv = 1'b1;
      if (!slv) begin
        if ((ba >> 2) >= 32'd1024) dec = 1'b1;
        else begin
          lo = int'(ba[1:0]);
          for (int k = 0; k < 4; k++) begin
            if (k >= lo && k < lo + (1 << size) && ws[i][k]) begin
              mdl[ba[11:2]][8*k +: 8] = wd[i][8*k +: 8];
              kn[ba[11:2]][k] = 1'b1;
            end
          end
        end
      end
    end
    eresp = slv ? 2'd2 : (dec ? 2'd3 : 2'd0);

    @(negedge aclk);
    axi.awid = id; axi.awaddr = addr; axi.awlen = 4'(len); axi.awsize = 3'(size);
    axi.awburst = 2'(burst); axi.awvalid = 1'b1;
    n = 0;
    while (!axi.awready && n < 50) begin @(negedge aclk); n++; end
    check("aw_ready", 32'(axi.awready), 32'd1);
    @(negedge aclk);
    axi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      axi.wvalid = 1'b1; axi.wid = id; axi.wdata = wd[i]; axi.wstrb = ws[i];
      axi.wlast = (early >= 0) ? (i == early) : (i == len);
      n = 0;
      while (!axi.wready && n < 50) begin @(negedge aclk); n++; end
      check("w_ready", 32'(axi.wready), 32'd1);
      @(negedge aclk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    check("b_valid_latency", 32'(axi.bvalid), 32'd1);
    for (int h = 0; h < bhold; h++) begin
      @(negedge aclk);
      check("b_hold_valid", 32'(axi.bvalid), 32'd1);
      check("aw_blocked", 32'(axi.awready), 32'd0);
    end
    check("bid", 32'(axi.bid), 32'(id));
    check("bresp", 32'(axi.bresp), 32'(eresp));
    axi.bready = 1'b1;
    @(negedge aclk);
    axi.bready = 1'b0;
    check("b_done", 32'(axi.bvalid), 32'd0);
    check("aw_ready_after_b", 32'(axi.awready), 32'd1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input int stall_beat, input int stall_cyc);
    bit bad;
    logic [31:0] ba, ed, m;
    logic [1:0] er;
    int n;
    bad = burst_bad(addr, len, size, burst);
    @(negedge aclk);
    axi.arid = id; axi.araddr = addr; axi.arlen = 4'(len); axi.arsize = 3'(size);
    axi.arburst = 2'(burst); axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 50) begin @(negedge aclk); n++; end
    check("ar_ready", 32'(axi.arready), 32'd1);
    @(negedge aclk);
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(addr, len, size, burst, i);
      if (bad) begin er = 2'd2; ed = '0; m = '1; end
      else if ((ba >> 2) >= 32'd1024) begin er = 2'd3; ed = '0; m = '1; end
      else begin
        er = 2'd0; ed = mdl[ba[11:2]];
        m = {{8{kn[ba[11:2]][3]}}, {8{kn[ba[11:2]][2]}}, {8{kn[ba[11:2]][1]}}, {8{kn[ba[11:2]][0]}}};
      end
      n = 0;
      while (!axi.rvalid && n < 50) begin @(negedge aclk); n++; end
      check("r_valid", 32'(axi.rvalid), 32'd1);
      check("rid", 32'(axi.rid), 32'(id));
      check("rresp", 32'(axi.rresp), 32'(er));
      if (m != 0) check("rdata", axi.rdata & m, ed & m);
      check("rlast", 32'(axi.rlast), 32'(i == len));
      if (i == stall_beat) begin
        axi.rready = 1'b0;
        for (int c = 0; c < stall_cyc; c++) begin
          @(negedge aclk);
          check("r_hold_valid", 32'(axi.rvalid), 32'd1);
          if (m != 0) check("r_hold_data", axi.rdata & m, ed & m);
          check("r_hold_last", 32'(axi.rlast), 32'(i == len));
        end
        axi.rready = 1'b1;
      end
      @(negedge aclk);
    end
    axi.rready = 1'b0;
    check("r_done", 32'(axi.rvalid), 32'd0);
    check("ar_ready_after_r", 32'(axi.arready), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int len, size, burst, sel;
    n_tests = 0; n_fail = 0;
    for (int i = 0; i < 1024; i++) begin mdl[i] = '0; kn[i] = '0; end
    aresetn = 1'b0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.arlock = '0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;

    // Reset held for three rising edges
    repeat (3) @(negedge aclk);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_wready",  32'(axi.wready),  32'd0);
    check("rst_bvalid",  32'(axi.bvalid),  32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_rvalid",  32'(axi.rvalid),  32'd0);
    check("rst_rlast",   32'(axi.rlast),   32'd0);
    check("rst_bresp",   32'(axi.bresp),   32'd0);
    check("rst_rresp",   32'(axi.rresp),   32'd0);
    check("rst_bid",     32'(axi.bid),     32'd0);
    check("rst_rid",     32'(axi.rid),     32'd0);
    check("rst_rdata",   axi.rdata,        32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_awready", 32'(axi.awready), 32'd1);
    check("post_rst_arready", 32'(axi.arready), 32'd1);

    // Fill words 0..63 with random data
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(4'(b), 32'(b * 64), 15, 2, 1, -1, 0);
    end

    // INCR write and read-back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd5, 32'h10, 3, 2, 1, -1, 0);
    do_read(4'd5, 32'h10, 3, 2, 1, -1, 0);

    // Narrow strobed byte write into 0x11223344
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'd2, 32'h20, 0, 2, 1, -1, 0);
    wd[0] = 32'h0000BB00; ws[0] = 4'h2;
    do_write(4'd2, 32'h21, 0, 0, 1, -1, 0);
    do_read(4'd2, 32'h20, 0, 2, 1, -1, 0);

    // WRAP read from 0x38
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE0030 + 32'(4 * i); ws[i] = 4'hF; end
    do_write(4'd3, 32'h30, 3, 2, 1, -1, 0);
    do_read(4'd3, 32'h38, 3, 2, 2, -1, 0);

    // Errors: out of range (aliases word 0 in the low bits), oversize, early wlast
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'd1, 32'h1000, 0, 2, 1, -1, 0);
    do_read(4'd1, 32'h0, 0, 2, 1, -1, 0);
    do_write(4'd1, 32'h40, 0, 3, 1, -1, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'd6, 32'h200, 3, 2, 1, 1, 0);

    // Backpressure on R and B
    do_read(4'd4, 32'h0, 7, 2, 1, 2, 5);
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'd7, 32'h80, 1, 2, 1, -1, 4);
    do_read(4'd7, 32'h80, 1, 2, 1, -1, 0);

    // Randomized bursts
    for (int t = 0; t < 80; t++) begin
      burst = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
      size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2) begin
        sel = int'($urandom_range(0, 9));
        len = (sel == 0) ? 2 : (1 << ($urandom_range(1, 4))) - 1;
      end else begin
        len = int'($urandom_range(0, 3));
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = 32'($urandom_range(0, 255));
      else if (sel < 9)  a = 32'h0FF0 + 32'($urandom_range(0, 15));
      else               a = 32'h1000 + 32'($urandom_range(0, 255));
      a = a & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(4'($urandom), a, len, size, burst, -1, int'($urandom_range(0, 2)));
      end else begin
        do_read(4'($urandom), a, len, size, burst, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
